// File: rtl/blob_src_tx.sv
// -----------------------------------------------------------------------------
// blob_src_tx
//   Transmit side of the layer blob stream (rdy/en/eop). On a start pulse it
//   reads one feature-map frame of FRAME_WORDS words from a fixed-latency
//   source RAM and streams it to a layer's blob_din port. Reads are prefetched
//   into a small output FIFO; a credit check (FIFO occupancy plus reads still
//   in the RAM pipe) keeps the FIFO from ever overflowing under back-pressure.
//
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   start           1-cycle pulse, accepted only when idle
//   busy / done     frame in progress / 1-cycle completion pulse
//   src_rd_*        source RAM read strobe, address, returned data (RD_LAT later)
//   blob_dout_rdy   consumer ready (used combinationally)
//   blob_dout_en    word transferred this cycle
//   blob_dout_eop   last word of the frame (only with blob_dout_en)
//   blob_dout       word data (FIFO head, 0 when empty)
//   stall_cnt       back-pressure cycle counter
//
// Build option
//   BLOB_SRC_TX_STALL_CNT_EN : when defined, stall_cnt counts (saturating)
//   cycles with busy=1, FIFO non-empty and blob_dout_rdy=0; cleared on an
//   accepted start. When undefined, stall_cnt is tied to 0.
// -----------------------------------------------------------------------------
module blob_src_tx #(
    parameter int DIN_W       = 128,
    parameter int FRAME_WORDS = 512,
    parameter int ADDR_W      = 9,
    parameter int BASE_ADDR   = 0,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [DIN_W-1:0]  src_rd_data,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic              blob_dout_eop,
    output logic [DIN_W-1:0]  blob_dout,
    output logic [31:0]       stall_cnt
);

    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [DIN_W-1:0]    mem_q [FIFO_DEPTH];
    logic [DIN_W-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic                fifo_ne;
    logic                push;
    logic                pop;
    logic                rd_issue;
    logic [OCC_W-1:0]    occ;

    always_comb begin
        fifo_ne = (fcnt_q != '0);
        push    = vld_q[RD_LAT-1];
        pop     = fifo_ne & blob_dout_rdy;

        // Credits: a read may only be issued if its word is guaranteed a FIFO
        // slot, counting words already buffered and words still in the RAM pipe.
        occ = OCC_W'(fcnt_q);
        for (int i = 0; i < RD_LAT; i++) begin
            occ = occ + OCC_W'(vld_q[i]);
        end
        rd_issue = (state_q == RUN) && (issued_q <= LAST_IDX) && (occ < OCC_MAX);

        state_d  = state_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        addr_d   = addr_q;

        if (rd_issue) begin
            issued_d = issued_q + CNT_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end
        if (pop) begin
            sent_d = sent_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    issued_d = '0;
                    sent_d   = '0;
                    addr_d   = BASE;
                end
            end
            RUN: begin
                if (rd_issue && (issued_q == LAST_IDX)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && (sent_q == LAST_IDX)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Read pipe: one valid bit per outstanding read, emerging with its data.
        vld_d = (vld_q << 1) | RD_LAT'(rd_issue);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = src_rd_data;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            issued_q <= '0;
            sent_q   <= '0;
            addr_q   <= BASE;
            vld_q    <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            sent_q   <= sent_d;
            addr_q   <= addr_d;
            vld_q    <= vld_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign src_rd_en     = rd_issue;
    assign src_rd_addr   = addr_q;
    assign blob_dout_en  = pop;
    assign blob_dout_eop = pop && (sent_q == LAST_IDX);
    assign blob_dout     = fifo_ne ? mem_q[rd_ptr_q] : '0;

`ifdef BLOB_SRC_TX_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if (busy && fifo_ne && !blob_dout_rdy && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
